// File: rtl/dog_pkg.sv
// dog_pkg: shared types and helpers for the dog sprite controller.
//   dog_state_t : controller FSM states
//   coord_t     : 12-bit unsigned screen coordinate
//   FRM_*       : sprite frame indices driven on frame_sel
//   reach_up/reach_down : "would this step land on or past the target" tests,
//                         evaluated in 13 bits so the step never wraps.
package dog_pkg;

    typedef logic [11:0] coord_t;

    typedef enum logic [3:0] {
        StIdle,
        StWalk1,
        StSniff,
        StWalk2,
        StJumpUp,
        StJumpDown,
        StHidden,
        StPopUp,
        StHold,
        StPopDown
    } dog_state_t;

    localparam logic [2:0] FRM_WALK_A  = 3'd0;
    localparam logic [2:0] FRM_WALK_B  = 3'd1;
    localparam logic [2:0] FRM_SNIFF   = 3'd2;
    localparam logic [2:0] FRM_JUMP    = 3'd3;
    localparam logic [2:0] FRM_DUCK    = 3'd4;
    localparam logic [2:0] FRM_LAUGH_A = 3'd5;
    localparam logic [2:0] FRM_LAUGH_B = 3'd6;

    function automatic logic reach_up(coord_t v, coord_t step, coord_t tgt);
        return ({1'b0, v} + {1'b0, step}) >= {1'b0, tgt};
    endfunction

    function automatic logic reach_down(coord_t v, coord_t step, coord_t tgt);
        return {1'b0, v} <= ({1'b0, tgt} + {1'b0, step});
    endfunction

endpackage

// File: rtl/dog_if.sv
// dog_if: signal bundle between game logic / video timing and the dog controller.
//   master : game side, drives game_enable, vblnk, show_req, show_type
//   slave  : dog_ctl, drives position, frame select and status flags
interface dog_if import dog_pkg::*; ();

    logic       game_enable;
    logic       vblnk;
    logic       show_req;
    logic       show_type;
    coord_t     xpos;
    coord_t     ypos;
    logic [2:0] frame_sel;
    logic       dog_visible;
    logic       behind_grass;
    logic       intro_done;
    logic       show_busy;
    logic       show_done;

    modport master (
        output game_enable, vblnk, show_req, show_type,
        input  xpos, ypos, frame_sel, dog_visible, behind_grass, intro_done,
               show_busy, show_done
    );

    modport slave (
        input  game_enable, vblnk, show_req, show_type,
        output xpos, ypos, frame_sel, dog_visible, behind_grass, intro_done,
               show_busy, show_done
    );

endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle frame tick on the rising edge of vblnk.
//   clk, rst : clock, synchronous active-high reset
//   i_vblnk  : vertical blank from the timing chain
//   o_tick   : high for the single clk in which vblnk is seen rising
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic i_vblnk,
    output logic o_tick
);

    logic r_vblnk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_q <= 1'b0;
        end else begin
            r_vblnk_q <= i_vblnk;
        end
    end

    assign o_tick = i_vblnk & ~r_vblnk_q;

endmodule

// File: rtl/dog_ctl.sv
// dog_ctl: per-frame motion and animation controller for the hunting dog sprite.
// Runs the intro (walk, sniff, walk, jump into the grass), then waits hidden for
// pop-up requests (hold caught duck, or laugh).
//   clk, rst : pixel clock, synchronous active-high reset
//   io_bus   : dog_if.slave - game_enable, vblnk, show_req, show_type in;
//              xpos, ypos, frame_sel, dog_visible, behind_grass, intro_done,
//              show_busy, show_done out (all registered)
// Build option: DOG_LAUGH_EN enables the laugh pop-up (show_type = 0). Without it a
// laugh request in HIDDEN just answers with a show_done pulse.
module dog_ctl import dog_pkg::*; #(
    parameter int unsigned X_START      = 0,
    parameter int unsigned X_SNIFF      = 240,
    parameter int unsigned X_JUMP       = 420,
    parameter int unsigned Y_GROUND     = 520,
    parameter int unsigned JUMP_HEIGHT  = 120,
    parameter int unsigned Y_HIDDEN     = 600,
    parameter int unsigned Y_POPUP      = 480,
    parameter int unsigned WALK_SPEED   = 2,
    parameter int unsigned JUMP_SPEED   = 4,
    parameter int unsigned SNIFF_FRAMES = 60,
    parameter int unsigned HOLD_FRAMES  = 45
) (
    input  logic clk,
    input  logic rst,
    dog_if.slave io_bus
);

    localparam coord_t     XStart    = coord_t'(X_START);
    localparam coord_t     XSniff    = coord_t'(X_SNIFF);
    localparam coord_t     XJump     = coord_t'(X_JUMP);
    localparam coord_t     YGround   = coord_t'(Y_GROUND);
    localparam coord_t     YApex     = coord_t'(Y_GROUND - JUMP_HEIGHT);
    localparam coord_t     YHidden   = coord_t'(Y_HIDDEN);
    localparam coord_t     YPopup    = coord_t'(Y_POPUP);
    localparam coord_t     WalkSpeed = coord_t'(WALK_SPEED);
    localparam coord_t     JumpSpeed = coord_t'(JUMP_SPEED);
    localparam logic [7:0] SniffLast = 8'(SNIFF_FRAMES - 1);
    localparam logic [7:0] HoldLast  = 8'(HOLD_FRAMES - 1);

`ifdef DOG_LAUGH_EN
    localparam logic LaughEn = 1'b1;
`else
    localparam logic LaughEn = 1'b0;
`endif

    logic w_tick;

    frame_tick_gen u_frame_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .i_vblnk (io_bus.vblnk),
        .o_tick  (w_tick)
    );

    dog_state_t r_state, w_state_d;
    coord_t     r_x, w_x_d, r_y, w_y_d;
    logic [7:0] r_cnt, w_cnt_d;
    logic [2:0] r_anim_cnt, w_anim_cnt_d;
    logic       r_anim_ph, w_anim_ph_d;
    logic       r_type, w_type_d;
    logic [2:0] r_frame, w_frame_d;
    logic       r_visible, w_visible_d;
    logic       r_behind, w_behind_d;
    logic       r_intro, w_intro_d;
    logic       r_busy, w_busy_d;
    logic       r_done, w_done_d;
    logic       w_accept;
    logic       w_animated;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic; also flags pop-up acceptance and completion
    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_done_d  = 1'b0;
        if (!io_bus.game_enable) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle:     if (w_tick) w_state_d = StWalk1;
                StWalk1:    if (w_tick && reach_up(r_x, WalkSpeed, XSniff)) w_state_d = StSniff;
                StSniff:    if (w_tick && r_cnt == SniffLast) w_state_d = StWalk2;
                StWalk2:    if (w_tick && reach_up(r_x, WalkSpeed, XJump)) w_state_d = StJumpUp;
                StJumpUp:   if (w_tick && reach_down(r_y, JumpSpeed, YApex)) w_state_d = StJumpDown;
                StJumpDown: if (w_tick && reach_up(r_y, JumpSpeed, YHidden)) w_state_d = StHidden;
                StHidden: begin
                    // Requests are sampled every clk here; a coincident tick is not a step.
                    if (io_bus.show_req) begin
                        if (io_bus.show_type || LaughEn) begin
                            w_accept  = 1'b1;
                            w_state_d = StPopUp;
                        end else begin
                            w_done_d = 1'b1;
                        end
                    end
                end
                StPopUp:    if (w_tick && reach_down(r_y, JumpSpeed, YPopup)) w_state_d = StHold;
                StHold:     if (w_tick && r_cnt == HoldLast) w_state_d = StPopDown;
                StPopDown: begin
                    if (w_tick && reach_up(r_y, JumpSpeed, YHidden)) begin
                        w_state_d = StHidden;
                        w_done_d  = 1'b1;
                    end
                end
                default:    w_state_d = StIdle;
            endcase
        end
    end

    assign w_animated = r_state inside {StWalk1, StWalk2, StPopUp, StHold, StPopDown};

    // Output / datapath next values; every output is registered from these
    always_comb begin
        w_x_d        = r_x;
        w_y_d        = r_y;
        w_cnt_d      = r_cnt;
        w_anim_cnt_d = r_anim_cnt;
        w_anim_ph_d  = r_anim_ph;
        w_type_d     = r_type;
        if (w_state_d == StIdle) begin
            w_x_d        = XStart;
            w_y_d        = YGround;
            w_cnt_d      = '0;
            w_anim_cnt_d = '0;
            w_anim_ph_d  = 1'b0;
            w_type_d     = 1'b0;
        end else begin
            if (w_tick) begin
                // Clamp to the target when the step would reach or pass it
                case (r_state)
                    StWalk1:   w_x_d = reach_up(r_x, WalkSpeed, XSniff) ? XSniff : r_x + WalkSpeed;
                    StWalk2:   w_x_d = reach_up(r_x, WalkSpeed, XJump) ? XJump : r_x + WalkSpeed;
                    StJumpUp:  w_y_d = reach_down(r_y, JumpSpeed, YApex) ? YApex : r_y - JumpSpeed;
                    StPopUp:   w_y_d = reach_down(r_y, JumpSpeed, YPopup) ? YPopup : r_y - JumpSpeed;
                    StJumpDown, StPopDown:
                               w_y_d = reach_up(r_y, JumpSpeed, YHidden) ? YHidden : r_y + JumpSpeed;
                    StSniff, StHold:
                               w_cnt_d = r_cnt + 8'd1;
                    default: ;
                endcase
                if (w_animated) begin
                    w_anim_cnt_d = r_anim_cnt + 3'd1;
                    if (r_anim_cnt == 3'd7) w_anim_ph_d = ~r_anim_ph;
                end
            end
            if (w_state_d != r_state) begin
                w_cnt_d = '0;
                if (w_state_d inside {StWalk1, StWalk2, StPopUp}) begin
                    w_anim_cnt_d = '0;
                    w_anim_ph_d  = 1'b0;
                end
            end
            if (w_accept) w_type_d = io_bus.show_type;
        end

        case (w_state_d)
            StWalk1, StWalk2:           w_frame_d = w_anim_ph_d ? FRM_WALK_B : FRM_WALK_A;
            StSniff:                    w_frame_d = FRM_SNIFF;
            StJumpUp, StJumpDown, StHidden:
                                        w_frame_d = FRM_JUMP;
            StPopUp, StHold, StPopDown:
                w_frame_d = w_type_d ? FRM_DUCK : (w_anim_ph_d ? FRM_LAUGH_B : FRM_LAUGH_A);
            default:                    w_frame_d = FRM_WALK_A;
        endcase

        w_visible_d = !(w_state_d inside {StIdle, StHidden});
        w_behind_d  = w_state_d inside {StJumpDown, StPopUp, StHold, StPopDown};
        w_busy_d    = w_state_d inside {StPopUp, StHold, StPopDown};
        // Sticky once hidden; only the return to IDLE clears it
        w_intro_d   = (w_state_d == StHidden) || (r_intro && w_state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= XStart;
            r_y        <= YGround;
            r_cnt      <= '0;
            r_anim_cnt <= '0;
            r_anim_ph  <= 1'b0;
            r_type     <= 1'b0;
            r_frame    <= FRM_WALK_A;
            r_visible  <= 1'b0;
            r_behind   <= 1'b0;
            r_intro    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_x        <= w_x_d;
            r_y        <= w_y_d;
            r_cnt      <= w_cnt_d;
            r_anim_cnt <= w_anim_cnt_d;
            r_anim_ph  <= w_anim_ph_d;
            r_type     <= w_type_d;
            r_frame    <= w_frame_d;
            r_visible  <= w_visible_d;
            r_behind   <= w_behind_d;
            r_intro    <= w_intro_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    assign io_bus.xpos         = r_x;
    assign io_bus.ypos         = r_y;
    assign io_bus.frame_sel    = r_frame;
    assign io_bus.dog_visible  = r_visible;
    assign io_bus.behind_grass = r_behind;
    assign io_bus.intro_done   = r_intro;
    assign io_bus.show_busy    = r_busy;
    assign io_bus.show_done    = r_done;

endmodule

// File: tb/tb_dog_ctl.sv
// tb_dog_ctl: self-checking bench for dog_ctl with default parameters.
// Expected values come from closed-form functions of the number of frame ticks
// since the intro started (or since a pop-up was accepted).
module tb_dog_ctl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   n_done;

    dog_if u_if ();

    dog_ctl u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial n_done = 0;
    always @(negedge clk) if (u_if.show_done) n_done++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Intro model, a = ticks since the dog entered WALK1
    function automatic int ix(int a);
        if (a <= 120) return 2 * a;
        if (a <= 180) return 240;
        return (240 + 2 * (a - 180) > 420) ? 420 : 240 + 2 * (a - 180);
    endfunction

    function automatic int iy(int a);
        if (a <= 270) return 520;
        if (a <= 300) return 520 - 4 * (a - 270);
        return (400 + 4 * (a - 300) > 600) ? 600 : 400 + 4 * (a - 300);
    endfunction

    function automatic int ifrm(int a);
        if (a < 120) return (a / 8) % 2;
        if (a < 180) return 2;
        if (a < 270) return ((a - 180) / 8) % 2;
        return 3;
    endfunction

    // Pop-up model, k = ticks since the request was accepted
    function automatic int py(int k);
        if (k <= 30) return 600 - 4 * k;
        if (k <= 75) return 480;
        return (480 + 4 * (k - 75) > 600) ? 600 : 480 + 4 * (k - 75);
    endfunction

    function automatic int pfrm(int k, bit typ);
        return typ ? 4 : 5 + (k / 8) % 2;
    endfunction

    task automatic chk_intro(input int a);
        chk("intro_x", int'(u_if.xpos), ix(a));
        chk("intro_y", int'(u_if.ypos), iy(a));
        if (a < 350) chk("intro_frame", int'(u_if.frame_sel), ifrm(a));
        chk("intro_visible", int'(u_if.dog_visible), int'(a < 350));
        chk("intro_behind", int'(u_if.behind_grass), int'(a >= 300 && a < 350));
        chk("intro_done", int'(u_if.intro_done), int'(a >= 350));
        chk("intro_busy", int'(u_if.show_busy), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, int'(u_if.xpos), 0);
        chk({tag, "_y"}, int'(u_if.ypos), 520);
        chk({tag, "_frame"}, int'(u_if.frame_sel), 0);
        chk({tag, "_flags"}, int'({u_if.dog_visible, u_if.behind_grass, u_if.intro_done,
                                   u_if.show_busy, u_if.show_done}), 0);
    endtask

    // One video frame: rising vblnk, random high/low lengths, optional stray request
    task automatic do_tick(input bit noise);
        @(negedge clk);
        u_if.vblnk = 1'b1;
        @(posedge clk);
        #1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        u_if.vblnk = 1'b0;
        if (noise && $urandom_range(0, 3) == 0) begin
            u_if.show_type = 1'($urandom_range(0, 1));
            u_if.show_req  = 1'b1;
            @(negedge clk);
            u_if.show_req  = 1'b0;
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic run_pop(input bit typ, input bit coincide);
        int base;
        base = n_done;
        @(negedge clk);
        u_if.show_type = typ;
        u_if.show_req  = 1'b1;
        if (coincide) u_if.vblnk = 1'b1;
        @(posedge clk);
        #1;
        u_if.show_req = 1'b0;
        chk("accept_busy", int'(u_if.show_busy), 1);
        chk("accept_y", int'(u_if.ypos), 600);
        if (coincide) begin
            @(negedge clk);
            u_if.vblnk = 1'b0;
            repeat (2) @(negedge clk);
        end
        for (int k = 1; k <= 105; k++) begin
            do_tick(1'b1);
            chk("pop_y", int'(u_if.ypos), py(k));
            chk("pop_x", int'(u_if.xpos), 420);
            if (k < 105) begin
                chk("pop_frame", int'(u_if.frame_sel), pfrm(k, typ));
                chk("pop_flags", int'({u_if.dog_visible, u_if.behind_grass, u_if.show_busy}), 7);
            end
        end
        chk("pop_done_count", n_done - base, 1);
        chk("pop_end_flags", int'({u_if.dog_visible, u_if.behind_grass, u_if.show_busy}), 0);
        chk("pop_end_intro", int'(u_if.intro_done), 1);
    endtask

    initial begin
        int base;
        int a_drop;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        u_if.game_enable = 1'b0;
        u_if.vblnk       = 1'b0;
        u_if.show_req    = 1'b0;
        u_if.show_type   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;

        // Disabled: vblnk keeps running, nothing may move
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            u_if.vblnk = 1'($urandom_range(0, 1));
        end
        u_if.vblnk = 1'b0;
        @(negedge clk);
        chk_reset_vals("disabled");

        // Intro: tick 1 leaves IDLE, then 350 ticks of motion
        u_if.game_enable = 1'b1;
        for (int n = 1; n <= 351; n++) begin
            do_tick(n <= 340);
            chk_intro(n - 1);
        end

        run_pop(1'b1, 1'b0);
        run_pop(1'b1, 1'b1);

`ifdef DOG_LAUGH_EN
        run_pop(1'b0, 1'b0);
`else
        base = n_done;
        @(negedge clk);
        u_if.show_type = 1'b0;
        u_if.show_req  = 1'b1;
        @(posedge clk);
        #1;
        u_if.show_req = 1'b0;
        chk("nolaugh_done", int'(u_if.show_done), 1);
        chk("nolaugh_busy", int'(u_if.show_busy), 0);
        @(posedge clk);
        #1;
        chk("nolaugh_done_end", int'(u_if.show_done), 0);
        repeat (3) do_tick(1'b0);
        chk("nolaugh_y", int'(u_if.ypos), 600);
        chk("nolaugh_visible", int'(u_if.dog_visible), 0);
        chk("nolaugh_count", n_done - base, 1);
`endif

        // Disable while hidden: back to IDLE, intro_done cleared, no done pulse
        base = n_done;
        @(negedge clk);
        u_if.game_enable = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("drop_hidden");

        // Re-run the intro and drop enable somewhere inside JUMP_UP
        a_drop = int'($urandom_range(271, 299));
        @(negedge clk);
        u_if.game_enable = 1'b1;
        for (int n = 1; n <= a_drop + 1; n++) begin
            do_tick(1'b1);
            chk_intro(n - 1);
        end
        @(negedge clk);
        u_if.game_enable = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("drop_jump");
        @(negedge clk);
        chk("drop_no_done", n_done - base, 0);

        // Synchronous reset in the middle of WALK1
        u_if.game_enable = 1'b1;
        for (int n = 1; n <= 10; n++) do_tick(1'b0);
        chk("prerst_x", int'(u_if.xpos), 18);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
